// File: rtl/ifetch_pkg.sv
// ifetch_pkg -- shared types and constants for the instruction fetch stage.
//   state_t   : fetch FSM states (BOOT, RUN, DRAIN)
//   XLEN      : address / instruction width
//   INST_BYTES: bytes per instruction word (PC increment)
//   qentry_t  : one fetch queue entry {pc, inst}
package ifetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } qentry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo -- synchronous FIFO with flush, used for the pc side-FIFO and
// the instruction queue of ifetch_stage.
//   clk, reset : clock, asynchronous active-low reset
//   flush      : empties the FIFO; overrides push and pop in the same cycle
//   push       : write push_data (ignored when full and not popping)
//   push_data  : entry to write
//   pop        : remove head (ignored when empty)
//   head       : current head entry (undefined when count == 0)
//   count      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module ifetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop on an empty FIFO is dropped, so push+pop while empty just pushes;
    // push while full is only taken when the head is leaving the same cycle.
    assign do_pop  = pop & (count != '0) & ~flush;
    assign do_push = push & ((count != FULL) | do_pop) & ~flush;

    assign head = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; only pointers and count are, and
    // the count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage -- fetch front-end upstream of the instruction cache.
// Owns the PC, issues word-aligned requests, queues returned words for decode
// and discards stale responses after a branch/trap redirect.
//   clk, reset           : clock, asynchronous active-low reset
//   redir_valid/redir_pc : redirect request and target (bits [1:0] ignored)
//   req_valid/req_addr   : fetch request to I-cache, req_ready accepts it
//   resp_valid/resp_data : in-order instruction word from I-cache
//   inst_valid/inst_data/inst_pc : queue head to decode, inst_ready pops it
// Optional macro IFETCH_PERF_CNT_EN adds saturating perf_fetched and
// perf_dropped counters.
module ifetch_stage
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          DEPTH        = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    output logic            req_valid,
    output logic [XLEN-1:0] req_addr,
    input  logic            req_ready,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] resp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped
`endif
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   q_count;
    logic [CW-1:0]   drop_after;
    logic [XLEN-1:0] resp_pc;
    qentry_t         q_head;
    qentry_t         q_push;
    logic            credit;
    logic            accept;
    logic            resp_keep;
    logic            resp_drop;

    // Every outstanding request owns one pc side-FIFO entry, so its occupancy
    // is the in-flight count.
    ifetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (accept),
        .push_data (pc),
        .pop       (resp_valid),
        .head      (resp_pc),
        .count     (inflight)
    );

    ifetch_fifo #(.WIDTH($bits(qentry_t)), .DEPTH(DEPTH)) u_inst_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redir_valid),
        .push      (resp_keep),
        .push_data (q_push),
        .pop       (inst_valid & inst_ready),
        .head      (q_head),
        .count     (q_count)
    );

    // Requests are only issued when a queue slot is guaranteed for the
    // response, which is why resp_valid needs no backpressure.
    assign credit    = ({1'b0, inflight} + {1'b0, q_count}) < DEPTH_W;
    assign req_valid = (state == RUN) & credit & ~redir_valid;
    assign req_addr  = pc;
    assign accept    = req_valid & req_ready;

    assign resp_keep  = resp_valid & ~redir_valid & (drop_cnt == '0);
    assign resp_drop  = resp_valid & ~resp_keep;
    assign q_push     = '{pc: resp_pc, inst: resp_data};
    // No request is accepted in a redirect cycle, so only a coincident
    // response can reduce the in-flight count.
    assign drop_after = inflight - CW'(resp_valid);

    assign inst_valid = (q_count != '0);
    assign inst_data  = inst_valid ? q_head.inst : '0;
    assign inst_pc    = inst_valid ? q_head.pc   : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            pc       <= RESET_VECTOR;
            drop_cnt <= '0;
        end else if (redir_valid) begin
            pc       <= redir_pc & ~XLEN'(3);
            drop_cnt <= drop_after;
            state    <= (drop_after != '0) ? DRAIN : RUN;
        end else begin
            if (accept)    pc       <= pc + XLEN'(INST_BYTES);
            if (resp_drop) drop_cnt <= drop_cnt - CW'(1);
            case (state)
                BOOT:    state <= RUN;
                RUN:     state <= RUN;
                DRAIN:   if (resp_drop && drop_cnt == CW'(1)) state <= RUN;
                default: state <= BOOT;
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (resp_keep && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
            if (resp_drop && perf_dropped != '1) perf_dropped <= perf_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage -- directed bench for ifetch_stage. A small I-cache model
// answers each accepted request with addr ^ 32'hA5A5_A5A5 after a configurable
// latency. Checks IFETCH_PERF_CNT_EN counters when that macro is defined.
module tb_ifetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;
    int n_acc  = 0;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    ifetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_dropped(perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes seen before the edge, then present the
    // next due cache response just after it.
    task automatic tick();
        #1;
        if (resp_valid) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (req_valid && req_ready) begin
            pend_addr.push_back(req_addr);
            pend_due.push_back(cyc + lat);
            n_acc++;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = pend_addr[0] ^ 32'hA5A5_A5A5;
        end else begin
            resp_valid = 1'b0;
            resp_data  = '0;
        end
    endtask

    task automatic do_reset(input string tag);
        reset       = 1'b0;
        redir_valid = 1'b0;
        resp_valid  = 1'b0;
        resp_data   = '0;
        pend_addr.delete();
        pend_due.delete();
        n_acc = 0;
        #1;
        chk({tag, "_req_valid"},  32'(req_valid),  0);
        chk({tag, "_req_addr"},   req_addr,        32'h0);
        chk({tag, "_inst_valid"}, 32'(inst_valid), 0);
        chk({tag, "_inst_data"},  inst_data,       32'h0);
        chk({tag, "_inst_pc"},    inst_pc,         32'h0);
`ifdef IFETCH_PERF_CNT_EN
        chk({tag, "_perf_fetched"}, perf_fetched, 32'h0);
        chk({tag, "_perf_dropped"}, perf_dropped, 32'h0);
`endif
        reset = 1'b1;
    endtask

    task automatic wait_inst(input string tag);
        int k = 0;
        while (!inst_valid && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_timeout"}, 32'(inst_valid), 1);
    endtask

    initial begin
        // Test 1: basic in-order fetch with a 1-cycle cache.
        do_reset("rst1");
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        lat        = 1;
        #1 chk("t1_boot_no_req", 32'(req_valid), 0);
        tick(); chk("t1_req_valid", 32'(req_valid), 1); chk("t1_addr0", req_addr, 32'h0);
        tick(); chk("t1_addr4", req_addr, 32'h4);
        tick(); chk("t1_inst_valid", 32'(inst_valid), 1);
                chk("t1_pc0", inst_pc, 32'h0); chk("t1_data0", inst_data, 32'hA5A5_A5A5);
        tick(); chk("t1_pc4", inst_pc, 32'h4); chk("t1_data4", inst_data, 32'hA5A5_A5A1);

        // Test 2: decode stalled -> exactly DEPTH requests, then resume.
        do_reset("rst2");
        inst_ready = 1'b0;
        repeat (12) tick();
        chk("t2_n_acc", 32'(n_acc), 4);
        chk("t2_stalled", 32'(req_valid), 0);
        chk("t2_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        tick();
        chk("t2_resume", 32'(req_valid), 1);
        chk("t2_resume_addr", req_addr, 32'h10);
        chk("t2_next_pc", inst_pc, 32'h4);

        // Test 3: redirect with 3 requests in flight, latency 4.
        do_reset("rst3");
        lat = 4;
        repeat (4) tick();
        chk("t3_pc_before", req_addr, 32'hC);
        redir_valid = 1'b1;
        redir_pc    = 32'h100;
        #1 chk("t3_redir_blocks_req", 32'(req_valid), 0);
        tick();
        redir_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_drain_no_req", 32'(req_valid), 0);
            chk("t3_drain_no_inst", 32'(inst_valid), 0);
            tick();
        end
        chk("t3_run_req", 32'(req_valid), 1);
        chk("t3_run_addr", req_addr, 32'h100);
        wait_inst("t3");
        chk("t3_first_pc", inst_pc, 32'h100);
        chk("t3_first_data", inst_data, 32'hA5A5_A4A5);
`ifdef IFETCH_PERF_CNT_EN
        chk("t3_perf_fetched", perf_fetched, 32'd1);
        chk("t3_perf_dropped", perf_dropped, 32'd3);
`endif

        // Test 4: redirect coincident with a response and a decode pop.
        do_reset("rst4");
        lat = 1;
        repeat (3) tick();
        chk("t4_setup_pc", inst_pc, 32'h0);
        chk("t4_setup_resp", 32'(resp_valid), 1);
        redir_valid = 1'b1;
        redir_pc    = 32'h203;
        #1 chk("t4_redir_blocks_req", 32'(req_valid), 0);
        tick();
        redir_valid = 1'b0;
        #1;
        chk("t4_flushed", 32'(inst_valid), 0);
        chk("t4_req_valid", 32'(req_valid), 1);
        chk("t4_req_addr", req_addr, 32'h200);
        tick(); tick();
        chk("t4_inst_valid", 32'(inst_valid), 1);
        chk("t4_inst_pc", inst_pc, 32'h200);
        chk("t4_inst_data", inst_data, 32'hA5A5_A7A5);

        // Test 5: PC wraps modulo 2^32.
        redir_valid = 1'b1;
        redir_pc    = 32'hFFFF_FFF8;
        tick();
        redir_valid = 1'b0;
        #1;
        chk("t5_req_valid", 32'(req_valid), 1);
        chk("t5_addr_f8", req_addr, 32'hFFFF_FFF8);
        tick(); chk("t5_addr_fc", req_addr, 32'hFFFF_FFFC);
        tick(); chk("t5_addr_wrap", req_addr, 32'h0000_0000);

        // Test 6: reset mid-stream with two requests in flight.
        lat = 3;
        tick(); tick();
        chk("t6_pc_before", req_addr, 32'h8);
        do_reset("t6_rst");
        tick();
        chk("t6_restart_req", 32'(req_valid), 1);
        chk("t6_restart_addr", req_addr, 32'h0);
        wait_inst("t6");
        chk("t6_first_pc", inst_pc, 32'h0);
        chk("t6_first_data", inst_data, 32'hA5A5_A5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
